// File: rtl/cu_pkg.sv
// Shared control-unit definitions used by the sequencer and microstore.
// Holds next-state select codes, condition select codes and default states.
package cu_pkg;

    localparam int STATE_W     = 10;
    localparam int RESET_STATE = 0;
    localparam int FETCH_STATE = 1;

    typedef enum logic [2:0] {
        NS_DECODE  = 3'b000,
        NS_FETCH   = 3'b001,
        NS_JUMP    = 3'b010,
        NS_INC     = 3'b011,
        NS_CJUMP   = 3'b100,
        NS_WAIT    = 3'b101,
        NS_CDECODE = 3'b110,
        NS_RSVD    = 3'b111
    } ns_e;

    typedef enum logic [1:0] {
        CS_MOC  = 2'b00,
        CS_COND = 2'b01,
        CS_ZERO = 2'b10,
        CS_ONE  = 2'b11
    } cs_e;

endpackage

// File: rtl/next_state_selector.sv
// Combinational next-state mux of the microprogram sequencer.
// A watchdog timeout overrides the select code and forces the error state.
module next_state_selector #(
    parameter int STATE_W     = cu_pkg::STATE_W,
    parameter int FETCH_STATE = cu_pkg::FETCH_STATE,
    parameter int ERROR_STATE = 1023
) (
    input  logic               i_c,
    input  logic [STATE_W-1:0] i_state,
    input  logic [STATE_W-1:0] i_inc,
    input  logic [STATE_W-1:0] i_encoded,
    input  logic [STATE_W-1:0] i_cr_next,
    input  logic [2:0]         i_cr_ns,
    input  logic               i_timeout,
    output logic [STATE_W-1:0] o_next
);
    import cu_pkg::*;

    localparam logic [STATE_W-1:0] LP_FETCH = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] LP_ERROR = STATE_W'(ERROR_STATE);

    always_comb begin
        o_next = LP_FETCH;
        if (i_timeout) begin
            o_next = LP_ERROR;
        end else begin
            case (i_cr_ns)
                NS_DECODE:  o_next = i_encoded;
                NS_FETCH:   o_next = LP_FETCH;
                NS_JUMP:    o_next = i_cr_next;
                NS_INC:     o_next = i_inc;
                NS_CJUMP:   o_next = i_c ? i_cr_next : i_inc;
                NS_WAIT:    o_next = i_c ? i_inc : i_state;
                NS_CDECODE: o_next = i_c ? i_encoded : LP_FETCH;
                default:    o_next = LP_FETCH;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microprogram sequencer: state register, condition mux, incrementer,
// memory-wait watchdog and sticky bus-error flag.
module control_sequencer #(
    parameter int STATE_W     = cu_pkg::STATE_W,
    parameter int RESET_STATE = cu_pkg::RESET_STATE,
    parameter int FETCH_STATE = cu_pkg::FETCH_STATE,
    parameter int ERROR_STATE = 1023,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [STATE_W-1:0] encoded_state,
    input  logic [STATE_W-1:0] cr_next,
    input  logic [2:0]         cr_ns,
    input  logic [1:0]         cr_cs,
    input  logic               cr_inv,
    input  logic               moc,
    input  logic               cond,
    output logic [STATE_W-1:0] state,
    output logic               bus_error
);
    import cu_pkg::*;

    localparam logic             LP_WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LP_TMAX  =
        CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [STATE_W-1:0] r_state;
    logic               r_bus_error;
    logic [CNT_W-1:0]   r_wcnt;

    logic               w_sel;
    logic               w_c;
    logic [STATE_W-1:0] w_inc;
    logic               w_waiting;
    logic               w_timeout;
    logic [STATE_W-1:0] w_next;

    always_comb begin
        w_sel = 1'b0;
        case (cr_cs)
            CS_MOC:  w_sel = moc;
            CS_COND: w_sel = cond;
            CS_ZERO: w_sel = 1'b0;
            CS_ONE:  w_sel = 1'b1;
            default: w_sel = 1'b0;
        endcase
    end

    assign w_c       = w_sel ^ cr_inv;
    assign w_inc     = r_state + STATE_W'(1);
    assign w_waiting = (cr_ns == NS_WAIT) && !w_c;
    // A condition arriving on the last allowed cycle still wins
    assign w_timeout = LP_WD_EN && w_waiting && (r_wcnt == LP_TMAX);

    next_state_selector #(
        .STATE_W     (STATE_W),
        .FETCH_STATE (FETCH_STATE),
        .ERROR_STATE (ERROR_STATE)
    ) u_sel (
        .i_c       (w_c),
        .i_state   (r_state),
        .i_inc     (w_inc),
        .i_encoded (encoded_state),
        .i_cr_next (cr_next),
        .i_cr_ns   (cr_ns),
        .i_timeout (w_timeout),
        .o_next    (w_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= STATE_W'(RESET_STATE);
            r_bus_error <= 1'b0;
            r_wcnt      <= '0;
        end else begin
            r_state <= w_next;
            if (w_timeout) begin
                r_bus_error <= 1'b1;
                r_wcnt      <= '0;
            end else if (w_waiting) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end else begin
                r_wcnt <= '0;
            end
        end
    end

    assign state     = r_state;
    assign bus_error = r_bus_error;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, hand-written
// wait/timeout sequences and a randomized run against a reference model.
module tb_control_sequencer;

    localparam int SW  = 10;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [SW-1:0] encoded_state;
    logic [SW-1:0] cr_next;
    logic [2:0]    cr_ns;
    logic [1:0]    cr_cs;
    logic          cr_inv;
    logic          moc;
    logic          cond;
    logic [SW-1:0] state;
    logic          bus_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_sequencer #(
        .STATE_W     (SW),
        .RESET_STATE (0),
        .FETCH_STATE (1),
        .ERROR_STATE (1023),
        .TIMEOUT     (TMO),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .encoded_state (encoded_state),
        .cr_next       (cr_next),
        .cr_ns         (cr_ns),
        .cr_cs         (cr_cs),
        .cr_inv        (cr_inv),
        .moc           (moc),
        .cond          (cond),
        .state         (state),
        .bus_error     (bus_error)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic [9:0] enc;
        logic [9:0] nxt;
        logic [2:0] ns;
        logic [1:0] cs;
        logic       inv;
        logic       m;
        logic       cd;
        int         exp_state;
        logic       exp_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string nm, logic r, int e, int n,
                                int ns, int cs, logic inv, logic m,
                                logic cd, int es, logic ee);
        vec_t v;
        v.name = nm; v.rst_n = r;
        v.enc = 10'(e); v.nxt = 10'(n);
        v.ns = 3'(ns); v.cs = 2'(cs);
        v.inv = inv; v.m = m; v.cd = cd;
        v.exp_state = es; v.exp_err = ee;
        return v;
    endfunction

    // Apply inputs, let one rising edge pass, settle just after it
    task automatic step(input logic r, input int e, input int n,
                        input int ns, input int cs, input logic inv,
                        input logic m, input logic cd);
        reset_n = r;
        encoded_state = 10'(e);
        cr_next = 10'(n);
        cr_ns = 3'(ns);
        cr_cs = 2'(cs);
        cr_inv = inv;
        moc = m;
        cond = cd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int es, input logic ee);
        checks++;
        if (state !== 10'(es) || bus_error !== ee) begin
            errors++;
            $display("FAIL %s: got state=%0d bus_error=%0b, want state=%0d bus_error=%0b",
                     nm, state, bus_error, es, ee);
        end
    endtask

    // Waits at state 20 for `holds` edges with moc low, then one more
    // edge with moc = last_moc.
    task automatic wait_run(input string nm, input int holds,
                            input logic last_moc, input logic last_rst,
                            input int exp_last, input logic exp_err);
        step(1, 0, 20, 2, 0, 0, 0, 0);
        check({nm, "_jump"}, 20, 0);
        for (int k = 0; k < holds; k++) begin
            step(1, 0, 0, 5, 0, 0, 0, 0);
            check({nm, "_hold"}, 20, 0);
        end
        step(last_rst, 0, 0, 5, 0, 0, last_moc, 0);
        check({nm, "_exit"}, exp_last, exp_err);
    endtask

    int   ms, mw;
    logic me;
    logic r, inv, m, cd, c, sel;
    int   e, n, ns, cs;
    bit   wait_bias;

    initial begin
        reset_n = 1'b0;
        encoded_state = '0; cr_next = '0;
        cr_ns = '0; cr_cs = '0;
        cr_inv = 1'b0; moc = 1'b0; cond = 1'b0;

        vt.push_back(mk("reset",      0,   0,   37, 2, 0, 0, 0, 0,   0, 0));
        vt.push_back(mk("reset_hold", 0,   0,   37, 2, 0, 0, 0, 0,   0, 0));
        vt.push_back(mk("rel_jump",   1,   0,   37, 2, 0, 0, 0, 0,  37, 0));
        vt.push_back(mk("fetch",      1,   0,    0, 1, 0, 0, 0, 0,   1, 0));
        vt.push_back(mk("decode",     1, 212,    0, 0, 0, 0, 0, 0, 212, 0));
        vt.push_back(mk("jump5",      1,   0,    5, 2, 0, 0, 0, 0,   5, 0));
        vt.push_back(mk("cdec_fail",  1, 212,    0, 6, 1, 0, 0, 0,   1, 0));
        vt.push_back(mk("cdec_pass",  1, 300,    0, 6, 1, 0, 0, 1, 300, 0));
        vt.push_back(mk("jump1022",   1,   0, 1022, 2, 0, 0, 0, 0, 1022, 0));
        vt.push_back(mk("inc1023",    1,   0,    0, 3, 0, 0, 0, 0, 1023, 0));
        vt.push_back(mk("inc_wrap",   1,   0,    0, 3, 0, 0, 0, 0,   0, 0));
        vt.push_back(mk("cjump_t",    1,   0,   50, 4, 3, 0, 0, 0,  50, 0));
        vt.push_back(mk("cjump_inv",  1,   0,   50, 4, 3, 1, 0, 0,  51, 0));
        vt.push_back(mk("reserved",   1,   0,   77, 7, 3, 0, 0, 0,   1, 0));
        vt.push_back(mk("cjump_z_inv",1,   0,    9, 4, 2, 1, 0, 0,   9, 0));
        vt.push_back(mk("wait_moc1",  1,   0,    0, 5, 0, 0, 1, 0,  10, 0));
        vt.push_back(mk("wait_inv",   1,   0,    0, 5, 0, 1, 0, 0,  11, 0));

        foreach (vt[i]) begin
            step(vt[i].rst_n, int'(vt[i].enc), int'(vt[i].nxt),
                 int'(vt[i].ns), int'(vt[i].cs),
                 vt[i].inv, vt[i].m, vt[i].cd);
            check(vt[i].name, vt[i].exp_state, vt[i].exp_err);
        end

        // moc arrives after three cycles of waiting
        wait_run("moc_wait", 3, 1'b1, 1'b1, 21, 1'b0);
        // moc never arrives: 16 cycles at 20, then the error state
        wait_run("timeout", TMO - 1, 1'b0, 1'b1, 1023, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 40 + k, 2, 0, 0, 0, 0);
            check("err_sticky", 40 + k, 1);
        end
        step(0, 0, 0, 5, 0, 0, 0, 0);
        check("err_reset", 0, 0);
        // moc on the timeout cycle wins
        wait_run("moc_last", TMO - 1, 1'b1, 1'b1, 21, 1'b0);
        // reset on the timeout cycle wins
        wait_run("rst_last", TMO - 1, 1'b0, 1'b0, 0, 1'b0);

        ms = 0; mw = 0; me = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            wait_bias = 1'($urandom_range(1));
            for (int i = 0; i < 40; i++) begin
                r   = ($urandom_range(127) != 0);
                e   = int'($urandom_range(1023));
                n   = int'($urandom_range(1023));
                if (wait_bias)
                    ns = ($urandom_range(15) != 0) ? 5 : int'($urandom_range(7));
                else
                    ns = int'($urandom_range(7));
                cs  = ($urandom_range(3) != 0) ? 0 : int'($urandom_range(3));
                inv = ($urandom_range(15) == 0);
                m   = wait_bias ? ($urandom_range(39) == 0)
                                : ($urandom_range(3) == 0);
                cd  = 1'($urandom_range(1));

                sel = (cs == 0) ? m : (cs == 1) ? cd : (cs == 2) ? 1'b0 : 1'b1;
                c   = sel ^ inv;
                if (!r) begin
                    ms = 0; mw = 0; me = 1'b0;
                end else begin
                    if (ns == 5 && !c) begin
                        if (mw == TMO - 1) begin
                            ms = 1023; me = 1'b1; mw = 0;
                        end else begin
                            mw = mw + 1;
                        end
                    end else begin
                        mw = 0;
                        case (ns)
                            0: ms = e;
                            2: ms = n;
                            3, 5: ms = (ms + 1) % 1024;
                            4: ms = c ? n : (ms + 1) % 1024;
                            6: ms = c ? e : 1;
                            default: ms = 1;
                        endcase
                    end
                end
                step(r, e, n, ns, cs, inv, m, cd);
                check("random", ms, me);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
